// File: rtl/iob_fifo_burst_ctrl.sv
// iob_fifo_burst_ctrl
//   Read-side controller for iob_fifo_sync. Waits until the FIFO holds a full
//   burst, then drains it onto a valid/ready stream with a last flag. If data
//   sits below the burst length for timeout_i WAIT cycles, a partial burst of
//   the current level is issued instead. A 2-entry skid buffer absorbs the
//   FIFO's 1-cycle read latency so the stream runs at 1 word/cycle.
// Ports
//   clk_i, cke_i, arst_i    clock, clock enable (all state holds when low), async reset (high)
//   en_i                    allow new bursts to start
//   burst_len_i             burst length in words (0 -> 1, clamped to FIFO depth)
//   timeout_i               WAIT cycles before a partial burst, 0 = never
//   fifo_level_i/empty_i    FIFO status
//   fifo_r_en_o/r_data_i    FIFO read port, data valid the cycle after the enable
//   m_valid_o/ready_i/data_o/last_o   output stream
//   busy_o                  burst in progress (BURST or DRAIN)
//   partial_o               1-cycle pulse when a timeout burst starts
module iob_fifo_burst_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int BURST_W   = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 arst_i,
    input  logic                 en_i,
    input  logic [BURST_W-1:0]   burst_len_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [ADDR_W:0]      fifo_level_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_r_en_o,
    input  logic [DATA_W-1:0]    fifo_r_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_W-1:0]    m_data_o,
    output logic                 m_last_o,
    output logic                 busy_o,
    output logic                 partial_o
);
    localparam int LVL_W = ADDR_W + 1;
    localparam int CMP_W = (BURST_W > LVL_W) ? BURST_W : LVL_W;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(1 << ADDR_W);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN} state_t;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
    logic [LVL_W-1:0]     rd_left_q, rd_left_d;
    logic [LVL_W-1:0]     out_left_q, out_left_d;
    logic [1:0]           buf_cnt_q, buf_cnt_d;
    logic [DATA_W-1:0]    buf0_q, buf0_d, buf1_q, buf1_d;
    logic                 inflight_q, inflight_d;

    logic [CMP_W-1:0]     len_ext;
    logic [LVL_W-1:0]     eff_len;
    logic [2:0]           occ;
    logic                 full_ok, tmo_hit, pop, rd_en, partial;

    // Effective burst length: 0 means 1, anything above the FIFO depth is clamped.
    always_comb begin
        len_ext = CMP_W'(burst_len_i);
        if (len_ext == '0)
            eff_len = LVL_W'(1);
        else if (len_ext > DEPTH_C)
            eff_len = LVL_W'(1 << ADDR_W);
        else
            eff_len = len_ext[LVL_W-1:0];
    end

    assign full_ok   = fifo_level_i >= eff_len;
    assign tmo_hit   = (timeout_i != '0) && (tmr_q == timeout_i - TIMEOUT_W'(1));
    assign m_valid_o = buf_cnt_q != 2'd0;
    assign m_data_o  = buf0_q;
    assign m_last_o  = m_valid_o && (out_left_q == LVL_W'(1));
    assign pop       = m_valid_o && m_ready_i;
    assign busy_o    = (state_q == S_BURST) || (state_q == S_DRAIN);

    // Skid occupancy after this edge, counting the word already in flight.
    // Reading only while it stays below 2 guarantees the buffer never overflows.
    assign occ   = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en = cke_i && (state_q == S_BURST) && (rd_left_q != '0) &&
                   !fifo_empty_i && (occ < 3'd2);
    assign fifo_r_en_o = rd_en;
    assign partial_o   = partial && cke_i;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        partial    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i && full_ok) begin
                    state_d    = S_BURST;
                    rd_left_d  = eff_len;
                    out_left_d = eff_len;
                end else if (en_i && !fifo_empty_i) begin
                    state_d = S_WAIT;
                    tmr_d   = '0;
                end
            end
            S_WAIT: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (full_ok) begin
                    state_d    = S_BURST;
                    rd_left_d  = eff_len;
                    out_left_d = eff_len;
                end else if (tmo_hit) begin
                    // Level is a safe burst size: nobody else reads the FIFO.
                    state_d    = S_BURST;
                    rd_left_d  = fifo_level_i;
                    out_left_d = fifo_level_i;
                    partial    = 1'b1;
                end else begin
                    tmr_d = tmr_q + TIMEOUT_W'(1);
                end
            end
            S_BURST: if (rd_left_q == '0) state_d = S_DRAIN;
            S_DRAIN: if (pop && m_last_o) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Reads only happen in BURST and pops only once data is buffered, so
        // these never collide with the counter loads above.
        if (rd_en) rd_left_d  = rd_left_q - LVL_W'(1);
        if (pop)   out_left_d = out_left_q - LVL_W'(1);
    end

    // Skid buffer: buf0 is the head presented on m_data_o, buf1 the overflow slot.
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf_cnt_d  = buf_cnt_q;
        inflight_d = rd_en;
        case ({inflight_q, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) buf0_d = fifo_r_data_i;
                else                   buf1_d = fifo_r_data_i;
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_d = fifo_r_data_i;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_r_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            buf_cnt_q  <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            inflight_q <= 1'b0;
        end else if (cke_i) begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            inflight_q <= inflight_d;
        end
    end
endmodule

// File: tb/tb_iob_fifo_burst_ctrl.sv
// Bench for iob_fifo_burst_ctrl: a queue models the FIFO (1-cycle read latency),
// a scoreboard tracks word order, burst sizes and framing, plus directed sequences.
module tb_iob_fifo_burst_ctrl;
    localparam int DATA_W = 32, ADDR_W = 4, BURST_W = 8, TIMEOUT_W = 16;
    localparam int DEPTH = 1 << ADDR_W;

    logic                 clk = 1'b0;
    logic                 cke_i, arst_i, en_i;
    logic [BURST_W-1:0]   burst_len_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [ADDR_W:0]      fifo_level_i;
    logic                 fifo_empty_i, fifo_r_en_o;
    logic [DATA_W-1:0]    fifo_r_data_i, m_data_o;
    logic                 m_valid_o, m_ready_i, m_last_o, busy_o, partial_o;

    always #5 clk = ~clk;

    iob_fifo_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
                          .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk_i(clk), .cke_i(cke_i), .arst_i(arst_i), .en_i(en_i),
        .burst_len_i(burst_len_i), .timeout_i(timeout_i),
        .fifo_level_i(fifo_level_i), .fifo_empty_i(fifo_empty_i),
        .fifo_r_en_o(fifo_r_en_o), .fifo_r_data_i(fifo_r_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_last_o(m_last_o), .busy_o(busy_o), .partial_o(partial_o)
    );

    int n_checks = 0, n_err = 0;
    logic [31:0] q[$];       // FIFO contents
    logic [31:0] exp_q[$];   // words expected on the stream, in order

    bit in_burst;
    int exp_n, acc_cnt, rd_cnt, outstanding, nbursts;
    int tot_acc, tot_last, tot_partial;
    bit have_prev, prev_cke, prev_busy, prev_en, prev_partial, prev_hold, prev_last;
    int prev_level, prev_eff;
    logic [31:0] prev_data;
    bit s_ren, s_acc, s_last, s_partial, s_busy;

    typedef struct {
        int len; int pre; int to; int bursts; int words; int part;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff(input int len);
        if (len == 0) return 1;
        if (len > DEPTH) return DEPTH;
        return len;
    endfunction

    task automatic upd_lvl();
        fifo_level_i = (ADDR_W+1)'(q.size());
        fifo_empty_i = (q.size() == 0);
    endtask

    task automatic push_word();
        logic [31:0] w;
        if (q.size() < DEPTH) begin
            w = $urandom;
            q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) push_word();
        upd_lvl();
    endtask

    // One clock cycle. Called at posedge+1; samples just before the next posedge,
    // then updates the FIFO model just after it.
    task automatic cyc(input bit push);
        #8;
        s_ren = fifo_r_en_o; s_busy = busy_o; s_last = m_last_o;
        s_partial = partial_o && cke_i;
        s_acc = cke_i && m_valid_o && m_ready_i;
        if (!cke_i) chk("ren_cke_low", 32'(fifo_r_en_o), 0);
        if (have_prev && prev_hold) begin
            chk("hold_valid", 32'(m_valid_o), 1);
            chk("hold_data", m_data_o, prev_data);
            chk("hold_last", 32'(m_last_o), 32'(prev_last));
        end
        if (have_prev) begin
            if (!prev_cke) begin
                chk("busy_hold_cke", 32'(busy_o), 32'(prev_busy));
            end else if (!prev_busy) begin
                chk("burst_start", 32'(busy_o),
                    32'(prev_partial || (prev_en && prev_level >= prev_eff)));
                if (busy_o) begin
                    chk("no_overlap", 32'(in_burst), 0);
                    if (prev_partial) chk("partial_below_full", 32'(prev_level < prev_eff), 1);
                    in_burst = 1; exp_n = prev_partial ? prev_level : prev_eff;
                    acc_cnt = 0; rd_cnt = 0; nbursts++;
                end
            end else if (!busy_o) begin
                chk("burst_words", acc_cnt, exp_n);
            end
        end
        if (partial_o) chk("partial_when_idle", 32'(busy_o), 0);
        if (s_ren) begin
            chk("ren_in_burst", 32'(in_burst), 1);
            chk("ren_fifo_nonempty", 32'(q.size() > 0), 1);
            chk("ren_within_n", 32'(rd_cnt < exp_n), 1);
            chk("ren_skid_room", 32'(outstanding - int'(s_acc) < 2), 1);
            rd_cnt++;
        end
        if (s_acc) begin
            chk("acc_in_burst", 32'(in_burst), 1);
            chk("acc_has_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("data", m_data_o, exp_q.pop_front());
            acc_cnt++; tot_acc++;
            if (m_last_o) tot_last++;
            chk("last", 32'(m_last_o), 32'(acc_cnt == exp_n));
            if (acc_cnt == exp_n) in_burst = 0;
        end
        if (s_partial) tot_partial++;
        outstanding += int'(s_ren) - int'(s_acc);
        prev_cke = cke_i; prev_busy = busy_o; prev_en = en_i;
        prev_level = q.size(); prev_eff = eff(int'(burst_len_i));
        prev_partial = s_partial;
        prev_hold = m_valid_o && !(m_ready_i && cke_i);
        prev_data = m_data_o; prev_last = m_last_o;
        have_prev = 1;
        @(posedge clk); #1;
        if (s_ren && q.size() > 0) fifo_r_data_i = q.pop_front();
        if (push) push_word();
        upd_lvl();
    endtask

    task automatic cleanup();
        en_i = 0; cke_i = 1; m_ready_i = 1;
        for (int i = 0; i < 100 && (busy_o || outstanding != 0); i++) cyc(0);
        chk("cleanup_idle", 32'(busy_o || outstanding != 0), 0);
        cyc(0); cyc(0);
        q.delete(); exp_q.delete(); upd_lvl();
        timeout_i = 0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ren"}, 32'(fifo_r_en_o), 0);
        chk({nm, "_valid"}, 32'(m_valid_o), 0);
        chk({nm, "_last"}, 32'(m_last_o), 0);
        chk({nm, "_data"}, m_data_o, 0);
        chk({nm, "_busy"}, 32'(busy_o), 0);
        chk({nm, "_partial"}, 32'(partial_o), 0);
    endtask

    initial begin
        logic [7:0] ren_v, acc_v;
        int nb0, a0, p0, l0, pidx;
        bit busy_seen, changed;

        cke_i = 1; arst_i = 1; en_i = 0; burst_len_i = 4; timeout_i = 0;
        m_ready_i = 1; fifo_r_data_i = 0; upd_lvl();
        #3;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1; arst_i = 0;

        // 1: six words preloaded, len 4, ready always high
        preload(6); burst_len_i = 4; en_i = 1;
        ren_v = '0; acc_v = '0; nb0 = nbursts;
        for (int i = 0; i < 8; i++) begin
            cyc(0); ren_v[i] = s_ren; acc_v[i] = s_acc;
            if (i == 6) chk("t1_last_cycle", 32'(s_last), 1);
        end
        chk("t1_ren_pattern", 32'(ren_v), 32'h1E);
        chk("t1_acc_pattern", 32'(acc_v), 32'h78);
        for (int i = 0; i < 10; i++) cyc(0);
        chk("t1_left_in_fifo", q.size(), 2);
        chk("t1_bursts", nbursts - nb0, 1);
        cleanup();

        // 2: same with ready toggling
        preload(6); burst_len_i = 4; en_i = 1; nb0 = nbursts; a0 = tot_acc;
        for (int i = 0; i < 40; i++) begin m_ready_i = (i % 2 == 0); cyc(0); end
        chk("t2_words", tot_acc - a0, 4);
        chk("t2_bursts", nbursts - nb0, 1);
        cleanup();

        // 3: partial burst after 10 WAIT cycles
        preload(3); burst_len_i = 8; timeout_i = 10; en_i = 1;
        a0 = tot_acc; p0 = tot_partial; pidx = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(0);
            if (s_partial && pidx < 0) pidx = i;
        end
        chk("t3_partial_cycle", pidx, 10);
        chk("t3_partial_count", tot_partial - p0, 1);
        chk("t3_words", tot_acc - a0, 3);
        chk("t3_fifo_empty", q.size(), 0);
        cleanup();

        // 4: no timeout, burst only once the 8th word lands
        burst_len_i = 8; timeout_i = 0; en_i = 1; nb0 = nbursts; a0 = tot_acc; busy_seen = 0;
        for (int i = 0; i < 3; i++) begin cyc(1); busy_seen |= s_busy; end
        for (int i = 0; i < 20; i++) begin cyc(0); busy_seen |= s_busy; end
        for (int i = 0; i < 5; i++) begin cyc(1); busy_seen |= s_busy; end
        chk("t4_no_early_burst", 32'(busy_seen), 0);
        for (int i = 0; i < 30; i++) cyc(0);
        chk("t4_bursts", nbursts - nb0, 1);
        chk("t4_words", tot_acc - a0, 8);
        cleanup();

        // 5: len and en change mid-burst
        preload(6); burst_len_i = 4; en_i = 1; nb0 = nbursts; a0 = tot_acc; l0 = tot_last;
        changed = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0);
            if (!changed && tot_acc - a0 == 2) begin burst_len_i = 2; en_i = 0; changed = 1; end
        end
        chk("t5_words", tot_acc - a0, 4);
        chk("t5_bursts", nbursts - nb0, 1);
        chk("t5_lasts", tot_last - l0, 1);
        chk("t5_left_in_fifo", q.size(), 2);
        cleanup();

        // 6: async reset mid-burst, then a full FIFO with clamped length
        preload(6); burst_len_i = 4; en_i = 1; a0 = tot_acc;
        for (int i = 0; i < 20 && tot_acc - a0 < 2; i++) cyc(0);
        chk("t6_reached_mid", tot_acc - a0, 2);
        #3; arst_i = 1; #1;
        chk_reset_outputs("t6_async");
        @(posedge clk); #1; arst_i = 0;
        exp_q = q; in_burst = 0; outstanding = 0; have_prev = 0;
        while (q.size() < DEPTH) push_word();
        upd_lvl();
        burst_len_i = 20; nb0 = nbursts; a0 = tot_acc;
        for (int i = 0; i < 40; i++) cyc(0);
        chk("t6_bursts", nbursts - nb0, 1);
        chk("t6_words", tot_acc - a0, DEPTH);
        cleanup();

        // Table: length boundaries and timeout edge values
        tbl[0] = '{0, 2, 0, 2, 2, 0};
        tbl[1] = '{1, 1, 0, 1, 1, 0};
        tbl[2] = '{5, 5, 0, 1, 5, 0};
        tbl[3] = '{16, 16, 0, 1, 16, 0};
        tbl[4] = '{200, 16, 0, 1, 16, 0};
        tbl[5] = '{3, 7, 0, 2, 6, 0};
        tbl[6] = '{8, 3, 4, 1, 3, 1};
        tbl[7] = '{3, 2, 1, 1, 2, 1};
        tbl[8] = '{17, 16, 0, 1, 16, 0};
        tbl[9] = '{17, 15, 0, 0, 0, 0};
        for (int t = 0; t < 10; t++) begin
            burst_len_i = BURST_W'(tbl[t].len); timeout_i = TIMEOUT_W'(tbl[t].to);
            preload(tbl[t].pre); en_i = 1;
            nb0 = nbursts; a0 = tot_acc; p0 = tot_partial;
            for (int i = 0; i < 50; i++) cyc(0);
            chk($sformatf("tbl%0d_bursts", t), nbursts - nb0, tbl[t].bursts);
            chk($sformatf("tbl%0d_words", t), tot_acc - a0, tbl[t].words);
            chk($sformatf("tbl%0d_partial", t), tot_partial - p0, tbl[t].part);
            cleanup();
        end

        // Random traffic against the scoreboard
        en_i = 1; burst_len_i = 4; timeout_i = 5;
        for (int i = 0; i < 3000; i++) begin
            cke_i = ($urandom % 10) != 0;
            en_i = ($urandom % 8) != 0;
            m_ready_i = ($urandom % 3) != 0;
            if ($urandom % 20 == 0) burst_len_i = BURST_W'($urandom % 20);
            if ($urandom % 20 == 0) timeout_i = TIMEOUT_W'($urandom % 8);
            cyc(($urandom % 2) == 1);
        end
        cleanup();
        chk("rand_drained", outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
